// File: rtl/oq_threshold_update_ctrl.sv
// Output-queue full-threshold update sequencer: one pending slot per queue, round-robin
// service, read-back confirmation. Optional ack watchdog: define OQ_THRESH_TIMEOUT_EN.
module oq_threshold_update_ctrl #(
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter int NUM_OQ_WIDTH      = 3,
    parameter int THRESH_WIDTH      = 19,
    parameter int TIMEOUT_CYCLES    = 255,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         update_req,
    input  logic [NUM_OQ_WIDTH-1:0]      update_oq,
    input  logic [THRESH_WIDTH-1:0]      update_value,
    output logic                         wr_req,
    output logic [NUM_OQ_WIDTH-1:0]      wr_oq,
    output logic [THRESH_WIDTH-1:0]      wr_value,
    input  logic                         wr_ack,
    input  logic [THRESH_WIDTH-1:0]      wr_readback,
    output logic                         done_pulse,
    output logic [NUM_OQ_WIDTH-1:0]      done_oq,
    output logic [NUM_OUTPUT_QUEUES-1:0] pending,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         coalesce_cnt,
    output logic [CNT_WIDTH-1:0]         mismatch_cnt,
    output logic [CNT_WIDTH-1:0]         timeout_cnt
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t                                     state;
    logic [NUM_OUTPUT_QUEUES-1:0][THRESH_WIDTH-1:0] pend_val;
    logic [NUM_OQ_WIDTH-1:0]                    last_served;
    logic [NUM_OQ_WIDTH-1:0]                    sel;
    logic [NUM_OQ_WIDTH-1:0]                    cand;
    logic                                       found;
    int                                         idx;
    logic                                       rb_match;
    logic                                       req_hits_wr;
    logic                                       expire;
    logic                                       retry;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Round-robin pick: first pending queue after last_served, wrapping.
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_OUTPUT_QUEUES; i++) begin
            idx  = (int'(last_served) + i) % NUM_OUTPUT_QUEUES;
            cand = NUM_OQ_WIDTH'(idx);
            if (!found && pending[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign rb_match    = (wr_readback == wr_value);
    assign req_hits_wr = update_req && (update_oq == wr_oq);

    // A failed write is retried only if nothing newer is queued for that slot.
    assign retry = (state == S_WAIT) && (wr_ack ? !rb_match : expire)
                   && !pending[wr_oq] && !req_hits_wr;

`ifdef OQ_THRESH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdog;

    assign expire = (state == S_WAIT) && !wr_ack && (wdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            wdog        <= '0;
            timeout_cnt <= '0;
        end else begin
            wdog <= (state == S_WAIT && !wr_ack && !expire) ? wdog + WD_W'(1) : '0;
            if (expire)
                timeout_cnt <= sat_inc(timeout_cnt);
        end
    end
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign timeout_cnt    = '0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            pend_val     <= '0;
            pending      <= '0;
            last_served  <= '0;
            wr_req       <= 1'b0;
            wr_oq        <= '0;
            wr_value     <= '0;
            done_pulse   <= 1'b0;
            done_oq      <= '0;
            busy         <= 1'b0;
            coalesce_cnt <= '0;
            mismatch_cnt <= '0;
        end else begin
            done_pulse <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (|pending) begin
                        wr_oq        <= sel;
                        wr_value     <= pend_val[sel];
                        pending[sel] <= 1'b0;
                        wr_req       <= 1'b1;
                        busy         <= 1'b1;
                        last_served  <= sel;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wr_ack) begin
                        wr_req <= 1'b0;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                        if (rb_match) begin
                            done_pulse <= 1'b1;
                            done_oq    <= wr_oq;
                        end else begin
                            mismatch_cnt <= sat_inc(mismatch_cnt);
                        end
                    end else if (expire) begin
                        wr_req <= 1'b0;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (retry) begin
                pending[wr_oq]  <= 1'b1;
                pend_val[wr_oq] <= wr_value;
            end

            // Capture comes last so a same-cycle request beats both the clear and the retry.
            if (update_req) begin
                pend_val[update_oq] <= update_value;
                pending[update_oq]  <= 1'b1;
                if (pending[update_oq])
                    coalesce_cnt <= sat_inc(coalesce_cnt);
            end
        end
    end

endmodule

// File: tb/tb_oq_threshold_update_ctrl.sv
// Scoreboard bench for oq_threshold_update_ctrl; also covers the OQ_THRESH_TIMEOUT_EN build.
module tb_oq_threshold_update_ctrl;

    localparam int NQ = 8;
    localparam int OW = 3;
    localparam int TW = 19;
    localparam int CW = 16;
`ifdef OQ_THRESH_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif
    localparam int ACK_DLY = 4;

    logic          clk;
    logic          reset;
    logic          update_req;
    logic [OW-1:0] update_oq;
    logic [TW-1:0] update_value;
    logic          wr_req;
    logic [OW-1:0] wr_oq;
    logic [TW-1:0] wr_value;
    logic          wr_ack;
    logic [TW-1:0] wr_readback;
    logic          done_pulse;
    logic [OW-1:0] done_oq;
    logic [NQ-1:0] pending;
    logic          busy;
    logic [CW-1:0] coalesce_cnt;
    logic [CW-1:0] mismatch_cnt;
    logic [CW-1:0] timeout_cnt;

    typedef struct {
        logic [OW-1:0] oq;
        logic [TW-1:0] val;
        bit            bad;
    } wr_exp_t;

    wr_exp_t       exp_wr_q[$];
    logic [OW-1:0] exp_done_q[$];
    int            n_chk = 0;
    int            n_err = 0;
    int            cyc = 0;
    bit            hold_ack = 0;
    int            wr_start_cyc = -1;
    int            last_len = 0;

    oq_threshold_update_ctrl #(
        .NUM_OUTPUT_QUEUES(NQ),
        .NUM_OQ_WIDTH     (OW),
        .THRESH_WIDTH     (TW),
        .TIMEOUT_CYCLES   (TO),
        .CNT_WIDTH        (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .update_req  (update_req),
        .update_oq   (update_oq),
        .update_value(update_value),
        .wr_req      (wr_req),
        .wr_oq       (wr_oq),
        .wr_value    (wr_value),
        .wr_ack      (wr_ack),
        .wr_readback (wr_readback),
        .done_pulse  (done_pulse),
        .done_oq     (done_oq),
        .pending     (pending),
        .busy        (busy),
        .coalesce_cnt(coalesce_cnt),
        .mismatch_cnt(mismatch_cnt),
        .timeout_cnt (timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic exp_wr(input logic [OW-1:0] oq, input logic [TW-1:0] val, input bit bad);
        wr_exp_t e;
        e.oq  = oq;
        e.val = val;
        e.bad = bad;
        exp_wr_q.push_back(e);
    endtask

    // Called at posedge+1; holds the request for exactly one cycle.
    task automatic req(input logic [OW-1:0] oq, input logic [TW-1:0] v);
        update_req   = 1'b1;
        update_oq    = oq;
        update_value = v;
        @(posedge clk);
        #1;
        update_req = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int max);
        bit ok = 0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (exp_wr_q.size() == 0 && exp_done_q.size() == 0 && !wr_req && !busy && pending == '0)
                ok = 1;
        end
        chk(tag, {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Register-block model plus write/done monitor.
    initial begin : responder
        bit            in_wr;
        int            cnt;
        bit            cur_bad;
        logic [OW-1:0] cur_oq;
        logic [TW-1:0] cur_val;
        wr_exp_t       e;
        in_wr       = 0;
        cnt         = 0;
        cur_bad     = 0;
        cur_oq      = '0;
        cur_val     = '0;
        wr_ack      = 1'b0;
        wr_readback = '0;
        forever begin
            @(negedge clk);
            wr_ack = 1'b0;
            if (done_pulse && reset) begin
                if (exp_done_q.size() == 0)
                    chk("done_spurious", {31'd0, done_pulse}, 32'd0);
                else
                    chk("done_oq", done_oq, exp_done_q.pop_front());
            end
            if (!reset) begin
                in_wr = 0;
            end else if (wr_req) begin
                if (!in_wr) begin
                    in_wr        = 1;
                    cnt          = 0;
                    wr_start_cyc = cyc;
                    if (exp_wr_q.size() == 0) begin
                        chk("wr_spurious", {31'd0, wr_req}, 32'd0);
                        cur_bad = 0;
                        cur_oq  = wr_oq;
                        cur_val = wr_value;
                    end else begin
                        e       = exp_wr_q.pop_front();
                        cur_bad = e.bad;
                        cur_oq  = e.oq;
                        cur_val = e.val;
                        chk("wr_oq", wr_oq, e.oq);
                        chk("wr_value", wr_value, e.val);
                    end
                end else begin
                    chk("wr_hold_oq", wr_oq, cur_oq);
                    chk("wr_hold_value", wr_value, cur_val);
                end
                cnt++;
                last_len = cnt;
                if (!hold_ack && cnt >= ACK_DLY) begin
                    wr_ack      = 1'b1;
                    wr_readback = cur_bad ? '0 : cur_val;
                    in_wr       = 0;
                end
            end else begin
                in_wr = 0;
            end
        end
    end

    initial begin : main
        int  t0;
        bit  seen;
        reset        = 1'b0;
        update_req   = 1'b0;
        update_oq    = '0;
        update_value = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_req", {31'd0, wr_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_done", {31'd0, done_pulse}, 32'd0);
        chk("rst_coalesce", coalesce_cnt, 32'd0);
        chk("rst_mismatch", mismatch_cnt, 32'd0);
        chk("rst_timeout", timeout_cnt, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single update: latency and write duration
        exp_wr(3'd2, 19'd57344, 0);
        exp_done_q.push_back(3'd2);
        t0 = cyc;
        req(3'd2, 19'd57344);
        wait_drain("t1_drain", 50);
        chk("t1_latency", wr_start_cyc - t0, 32'd2);
        chk("t1_wr_len", last_len, ACK_DLY);
        chk("t1_pending", pending, 32'd0);

        // Round-robin with wrap back to queue 0
        hold_ack = 1;
        exp_wr(3'd0, 19'd1000, 0);
        exp_wr(3'd1, 19'd1001, 0);
        exp_wr(3'd5, 19'd1005, 0);
        exp_wr(3'd7, 19'd1007, 0);
        exp_wr(3'd0, 19'd2000, 0);
        exp_done_q.push_back(3'd0);
        exp_done_q.push_back(3'd1);
        exp_done_q.push_back(3'd5);
        exp_done_q.push_back(3'd7);
        exp_done_q.push_back(3'd0);
        req(3'd0, 19'd1000);
        req(3'd5, 19'd1005);
        req(3'd1, 19'd1001);
        req(3'd7, 19'd1007);
        req(3'd0, 19'd2000);
        @(negedge clk);
        chk("t2_pending", pending, 32'hA3);
        chk("t2_busy", {31'd0, busy}, 32'd1);
        hold_ack = 0;
        wait_drain("t2_drain", 100);
        chk("t2_coalesce", coalesce_cnt, 32'd0);

        // Coalescing while busy
        hold_ack = 1;
        exp_wr(3'd0, 19'd100, 0);
        exp_wr(3'd3, 19'd28672, 0);
        exp_done_q.push_back(3'd0);
        exp_done_q.push_back(3'd3);
        req(3'd0, 19'd100);
        req(3'd3, 19'd43008);
        req(3'd3, 19'd28672);
        @(negedge clk);
        chk("t3_coalesce", coalesce_cnt, 32'd1);
        chk("t3_pending", pending, 32'h08);
        hold_ack = 0;
        wait_drain("t3_drain", 60);

        // Readback mismatch then retry
        exp_wr(3'd4, 19'd14336, 1);
        exp_wr(3'd4, 19'd14336, 0);
        exp_done_q.push_back(3'd4);
        req(3'd4, 19'd14336);
        wait_drain("t4_drain", 60);
        chk("t4_mismatch", mismatch_cnt, 32'd1);
        chk("t4_coalesce", coalesce_cnt, 32'd1);

        // Same-cycle capture beats the selection clear
        exp_wr(3'd6, 19'd300, 0);
        exp_wr(3'd6, 19'd301, 0);
        exp_done_q.push_back(3'd6);
        exp_done_q.push_back(3'd6);
        req(3'd6, 19'd300);
        req(3'd6, 19'd301);
        wait_drain("t5_drain", 60);
        chk("t5_coalesce", coalesce_cnt, 32'd2);
        chk("t5_mismatch", mismatch_cnt, 32'd1);

        // Unacknowledged write
        hold_ack = 1;
`ifdef OQ_THRESH_TIMEOUT_EN
        exp_wr(3'd1, 19'd500, 0);
        exp_wr(3'd1, 19'd500, 0);
        req(3'd1, 19'd500);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (wr_req) seen = 1;
            else if (seen) break;
        end
        chk("to_dropped", {31'd0, wr_req}, 32'd0);
        chk("to_len", last_len, TO);
        chk("to_cnt", timeout_cnt, 32'd1);
        chk("to_repend", {31'd0, pending[1]}, 32'd1);
        for (int i = 0; i < 20 && !wr_req; i++) @(negedge clk);
        chk("to_reissue", {31'd0, wr_req}, 32'd1);
`else
        exp_wr(3'd1, 19'd500, 0);
        req(3'd1, 19'd500);
        seen = 0;
        repeat (1000) @(negedge clk);
        chk("noto_wr_req", {31'd0, wr_req}, 32'd1);
        chk("noto_busy", {31'd0, busy}, 32'd1);
        chk("noto_cnt", timeout_cnt, 32'd0);
`endif

        // Reset in the middle of WAIT with three queues pending
        @(posedge clk);
        #1;
        req(3'd2, 19'd1);
        req(3'd3, 19'd2);
        req(3'd5, 19'd3);
        @(negedge clk);
        chk("pre_rst_pending", pending, 32'h2C);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_wr_req", {31'd0, wr_req}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_pending", pending, 32'd0);
        chk("mid_rst_coalesce", coalesce_cnt, 32'd0);
        chk("mid_rst_mismatch", mismatch_cnt, 32'd0);
        chk("mid_rst_timeout", timeout_cnt, 32'd0);
        hold_ack = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Recovery after reset
        exp_wr(3'd7, 19'd9, 0);
        exp_done_q.push_back(3'd7);
        req(3'd7, 19'd9);
        wait_drain("t7_drain", 50);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
